cv32e40x_lsu_rsp_align: RTL and testbench

LSU response aligner sitting directly upstream of the write-back stage. It records per-transaction attributes at OBI request acceptance, consumes OBI responses in order, merges the two halves of misaligned (split) loads, and applies byte-lane alignment and sign/zero extension. It presents one result per load/store instruction to WB over a valid/ready handshake. Buffering is credit-protected, so an OBI response, which cannot be back-pressured, is never dropped.

---
 rtl/cv32e40x_pkg.sv | 49 ++++
 rtl/cv32e40x_ff_fifo.sv | 75 +++++++
 rtl/cv32e40x_lsu_rsp_align_chk.sv | 45 ++++
 rtl/cv32e40x_lsu_rsp_align.sv | 157 +++++++++++++++
 tb/tb_cv32e40x_lsu_rsp_align.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the LSU response path.
// Contents:
//   lsu_size_e        access size encoding (BYTE/HALF/WORD, 2'b11 unused)
//   lsu_split_e       position of a transaction within a misaligned access
//   lsu_trans_info_t  attributes captured when an OBI request is accepted
//   lsu_rsp_t         one finished result handed to write-back
//   lsu_extend()      selects the load width and applies sign/zero extension
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        SPLIT_NONE   = 2'b00,
        SPLIT_FIRST  = 2'b01,
        SPLIT_SECOND = 2'b10
    } lsu_split_e;

    typedef struct packed {
        logic       we;
        lsu_size_e  size;
        logic       sext;
        logic [1:0] offset;
        lsu_split_e split;
    } lsu_trans_info_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } lsu_rsp_t;

    // Data is already shifted so the addressed byte sits in bits [7:0].
    function automatic logic [31:0] lsu_extend(input logic [31:0] data,
                                               input lsu_size_e   size,
                                               input logic        sext);
        logic [31:0] result;
        case (size)
            BYTE:    result = {{24{sext & data[7]}}, data[7:0]};
            HALF:    result = {{16{sext & data[15]}}, data[15:0]};
            WORD:    result = data;
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cv32e40x_ff_fifo.sv
// Flip-flop based FIFO, generic over depth and entry type.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the tail (ignored when full and not popping)
//   push_data   entry to write
//   pop         drop the head entry (ignored when empty)
//   head        current head entry, straight from storage flops
//   count       number of stored entries (0..DEPTH)
module cv32e40x_ff_fifo #(
    parameter int  DEPTH  = 2,
    parameter type data_t = logic [7:0]
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  data_t                        push_data,
    input  logic                         pop,
    output data_t                        head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    data_t          mem_r [DEPTH];
    logic [PW-1:0]  wptr_r;
    logic [PW-1:0]  rptr_r;
    logic [CW-1:0]  count_r;
    logic           push_ok_s;
    logic           pop_ok_s;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + PTR_ONE;
    endfunction

    // Qualify requests against the current fill level.
    always_comb begin
        pop_ok_s  = pop && (count_r != {CW{1'b0}});
        push_ok_s = push && ((count_r != DEPTH_CNT) || pop_ok_s);
    end

    // Storage, pointers and fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r] <= push_data;
                wptr_r        <= next_ptr(wptr_r);
            end
            if (pop_ok_s) begin
                rptr_r <= next_ptr(rptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rptr_r];
    assign count = count_r;

endmodule

// File: rtl/cv32e40x_lsu_rsp_align_chk.sv
// Protocol checker for the inputs of cv32e40x_lsu_rsp_align.
// Ports: the DUT's clk, rst, request handshake/attributes and resp_valid_i.
// Tracks outstanding requests and open split accesses on its own.
module cv32e40x_lsu_rsp_align_chk (
    input logic       clk,
    input logic       rst,
    input logic       trans_valid_i,
    input logic       trans_ready_o,
    input logic [1:0] trans_size_i,
    input logic [1:0] trans_split_i,
    input logic       resp_valid_i
);

    logic [7:0] outstanding_r;
    logic       first_open_r;

    // Shadow count of requests awaiting a response, and open split state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= 8'd0;
            first_open_r  <= 1'b0;
        end else begin
            case ({trans_valid_i, resp_valid_i})
                2'b10:   outstanding_r <= outstanding_r + 8'd1;
                2'b01:   outstanding_r <= outstanding_r - 8'd1;
                default: outstanding_r <= outstanding_r;
            endcase
            if (trans_valid_i && (trans_split_i == 2'b01)) begin
                first_open_r <= 1'b1;
            end else if (trans_valid_i && (trans_split_i == 2'b10)) begin
                first_open_r <= 1'b0;
            end
        end
    end

    a_resp_has_info: assert property (@(posedge clk) disable iff (rst)
        resp_valid_i |-> (outstanding_r != 8'd0));
    a_trans_has_credit: assert property (@(posedge clk) disable iff (rst)
        trans_valid_i |-> trans_ready_o);
    a_trans_size_legal: assert property (@(posedge clk) disable iff (rst)
        trans_valid_i |-> (trans_size_i != 2'b11));
    a_second_after_first: assert property (@(posedge clk) disable iff (rst)
        (trans_valid_i && (trans_split_i == 2'b10)) |-> first_open_r);

endmodule

// File: rtl/cv32e40x_lsu_rsp_align.sv
// LSU response aligner in front of write-back.
// Captures per-transaction attributes at OBI request acceptance, pairs them
// in order with OBI responses, merges the halves of misaligned loads, aligns
// and extends load data, and buffers one result per instruction for WB.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   trans_*          attributes of an OBI request accepted this cycle
//   trans_ready_o    credit available; EX must not issue while low
//   resp_*           OBI rvalid / rdata / err (cannot be back-pressured)
//   lsu_valid_o/lsu_ready_i  result handshake towards WB
//   lsu_rdata_o      aligned, extended load data (0 for stores)
//   lsu_err_o        bus error, ORed over both halves of a split access
module cv32e40x_lsu_rsp_align
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trans_valid_i,
    output logic        trans_ready_o,
    input  logic        trans_we_i,
    input  logic [1:0]  trans_size_i,
    input  logic        trans_sext_i,
    input  logic [1:0]  trans_offset_i,
    input  logic [1:0]  trans_split_i,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_rdata_i,
    input  logic        resp_err_i,
    output logic        lsu_valid_o,
    input  logic        lsu_ready_i,
    output logic [31:0] lsu_rdata_o,
    output logic        lsu_err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

    lsu_trans_info_t info_push_data_s;
    lsu_trans_info_t info_head_s;
    logic [CW-1:0]   info_cnt_s;
    logic            info_pop_s;

    lsu_rsp_t        res_push_data_s;
    lsu_rsp_t        res_head_s;
    logic [CW-1:0]   res_cnt_s;
    logic            res_push_s;
    logic            res_pop_s;

    logic [31:0]     hold_data_r;
    logic            hold_err_r;
    logic            hold_valid_r;

    logic [4:0]      shift_lo_s;
    logic [5:0]      shift_hi_s;
    logic [31:0]     aligned_s;
    logic [31:0]     merged_s;
    logic            merged_err_s;
    logic [CW:0]     credit_used_s;

    // Pack request attributes for the info FIFO.
    always_comb begin
        info_push_data_s        = '0;
        info_push_data_s.we     = trans_we_i;
        info_push_data_s.size   = lsu_size_e'(trans_size_i);
        info_push_data_s.sext   = trans_sext_i;
        info_push_data_s.offset = trans_offset_i;
        info_push_data_s.split  = lsu_split_e'(trans_split_i);
    end

    cv32e40x_ff_fifo #(
        .DEPTH  (DEPTH),
        .data_t (lsu_trans_info_t)
    ) u_info_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (trans_valid_i),
        .push_data (info_push_data_s),
        .pop       (info_pop_s),
        .head      (info_head_s),
        .count     (info_cnt_s)
    );

    // Align the response against the head transaction and build the result.
    // A second half brings the upper bytes: they land above the bytes that
    // the first half contributed, i.e. at bit 8*(4-offset).
    always_comb begin
        info_pop_s      = resp_valid_i && (info_cnt_s != {CW{1'b0}});
        shift_lo_s      = {info_head_s.offset, 3'b000};
        shift_hi_s      = 6'd32 - {1'b0, info_head_s.offset, 3'b000};
        aligned_s       = resp_rdata_i >> shift_lo_s;
        res_push_data_s = '0;
        if (info_head_s.split == SPLIT_SECOND) begin
            // Without a captured first half there is nothing valid to merge.
            merged_s     = (hold_valid_r ? hold_data_r : 32'd0) | (resp_rdata_i << shift_hi_s);
            merged_err_s = (hold_valid_r & hold_err_r) | resp_err_i;
        end else begin
            merged_s     = aligned_s;
            merged_err_s = resp_err_i;
        end
        if (info_head_s.we) begin
            res_push_data_s.rdata = 32'd0;
        end else begin
            res_push_data_s.rdata = lsu_extend(merged_s, info_head_s.size, info_head_s.sext);
        end
        res_push_data_s.err = merged_err_s;
        res_push_s = info_pop_s && (info_head_s.split != SPLIT_FIRST);
    end

    // First-half capture register for split accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_r  <= 32'd0;
            hold_err_r   <= 1'b0;
            hold_valid_r <= 1'b0;
        end else if (info_pop_s) begin
            if (info_head_s.split == SPLIT_FIRST) begin
                hold_data_r  <= aligned_s;
                hold_err_r   <= resp_err_i;
                hold_valid_r <= 1'b1;
            end else if (info_head_s.split == SPLIT_SECOND) begin
                hold_valid_r <= 1'b0;
            end
        end
    end

    cv32e40x_ff_fifo #(
        .DEPTH  (DEPTH),
        .data_t (lsu_rsp_t)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_push_s),
        .push_data (res_push_data_s),
        .pop       (res_pop_s),
        .head      (res_head_s),
        .count     (res_cnt_s)
    );

    // WB outputs come from the result FIFO head flops and registered count;
    // an issued transaction holds its credit until its result leaves, so a
    // response always finds a free result slot.
    always_comb begin
        credit_used_s = {1'b0, info_cnt_s} + {1'b0, res_cnt_s};
        trans_ready_o = (credit_used_s < CREDIT_MAX);
        lsu_valid_o   = (res_cnt_s != {CW{1'b0}});
        res_pop_s     = lsu_valid_o && lsu_ready_i;
        if (lsu_valid_o) begin
            lsu_rdata_o = res_head_s.rdata;
            lsu_err_o   = res_head_s.err;
        end else begin
            lsu_rdata_o = 32'd0;
            lsu_err_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_cv32e40x_lsu_rsp_align.sv
// Directed, scoreboard-based bench for cv32e40x_lsu_rsp_align (DEPTH=2).
module tb_cv32e40x_lsu_rsp_align;
    import cv32e40x_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trans_valid_i = 1'b0;
    logic        trans_ready_o;
    logic        trans_we_i = 1'b0;
    logic [1:0]  trans_size_i = 2'b00;
    logic        trans_sext_i = 1'b0;
    logic [1:0]  trans_offset_i = 2'b00;
    logic [1:0]  trans_split_i = 2'b00;
    logic        resp_valid_i = 1'b0;
    logic [31:0] resp_rdata_i = 32'd0;
    logic        resp_err_i = 1'b0;
    logic        lsu_valid_o;
    logic        lsu_ready_i = 1'b0;
    logic [31:0] lsu_rdata_o;
    logic        lsu_err_o;

    typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
    typedef struct packed { logic [1:0] size; logic sext; logic [1:0] off; logic we; } ld_t;

    exp_t        sb[$];
    ld_t         pend[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_rdata = 32'd0;
    logic        prev_err = 1'b0;

    always #5 clk = ~clk;

    cv32e40x_lsu_rsp_align #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .trans_valid_i  (trans_valid_i),
        .trans_ready_o  (trans_ready_o),
        .trans_we_i     (trans_we_i),
        .trans_size_i   (trans_size_i),
        .trans_sext_i   (trans_sext_i),
        .trans_offset_i (trans_offset_i),
        .trans_split_i  (trans_split_i),
        .resp_valid_i   (resp_valid_i),
        .resp_rdata_i   (resp_rdata_i),
        .resp_err_i     (resp_err_i),
        .lsu_valid_o    (lsu_valid_o),
        .lsu_ready_i    (lsu_ready_i),
        .lsu_rdata_o    (lsu_rdata_o),
        .lsu_err_o      (lsu_err_o)
    );

    cv32e40x_lsu_rsp_align_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .trans_valid_i (trans_valid_i),
        .trans_ready_o (trans_ready_o),
        .trans_size_i  (trans_size_i),
        .trans_split_i (trans_split_i),
        .resp_valid_i  (resp_valid_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference load result built from byte lanes of the bus word.
    function automatic logic [31:0] exp_load(input logic [31:0] rd, input ld_t ld);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'd0;
        h = 16'd0;
        case (ld.off)
            2'd0: begin b = rd[7:0];   h = rd[15:0];  end
            2'd1: begin b = rd[15:8];  h = rd[23:8];  end
            2'd2: begin b = rd[23:16]; h = rd[31:16]; end
            default: b = rd[31:24];
        endcase
        if (ld.we) r = 32'd0;
        else if (ld.size == 2'd0) r = (ld.sext && b[7]) ? {24'hFFFFFF, b} : {24'd0, b};
        else if (ld.size == 2'd1) r = (ld.sext && h[15]) ? {16'hFFFF, h} : {16'd0, h};
        else r = rd;
        return r;
    endfunction

    // Compare a result being accepted this cycle and check hold stability.
    task automatic observe();
        exp_t e;
        if (prev_hold) begin
            chk("hold_valid", {31'd0, lsu_valid_o}, 32'd1);
            chk("hold_rdata", lsu_rdata_o, prev_rdata);
            chk("hold_err", {31'd0, lsu_err_o}, {31'd0, prev_err});
        end
        if (lsu_valid_o === 1'b1 && lsu_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {31'd0, lsu_valid_o}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("res_rdata", lsu_rdata_o, e.rdata);
                chk("res_err", {31'd0, lsu_err_o}, {31'd0, e.err});
            end
        end
        prev_hold  = lsu_valid_o && !lsu_ready_i;
        prev_rdata = lsu_rdata_o;
        prev_err   = lsu_err_o;
    endtask

    task automatic set_in(input logic tv, input logic [1:0] tsz, input logic tsx,
                          input logic [1:0] toff, input logic [1:0] tsp, input logic twe,
                          input logic rv, input logic [31:0] rd, input logic re, input logic rdy);
        trans_valid_i  = tv;
        trans_size_i   = tsz;
        trans_sext_i   = tsx;
        trans_offset_i = toff;
        trans_split_i  = tsp;
        trans_we_i     = twe;
        resp_valid_i   = rv;
        resp_rdata_i   = rd;
        resp_err_i     = re;
        lsu_ready_i    = rdy;
    endtask

    task automatic idle(input logic rdy);
        @(negedge clk);
        set_in(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, rdy);
        #1;
        observe();
    endtask

    task automatic issue(input logic [1:0] tsz, input logic tsx, input logic [1:0] toff,
                         input logic [1:0] tsp, input logic twe, input logic rdy);
        @(negedge clk);
        set_in(1'b1, tsz, tsx, toff, tsp, twe, 1'b0, 32'd0, 1'b0, rdy);
        #1;
        observe();
    endtask

    task automatic respond(input logic [31:0] rd, input logic re, input logic rdy);
        @(negedge clk);
        set_in(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, rd, re, rdy);
        #1;
        observe();
    endtask

    // Issue one non-split access, answer it, and check the 1-cycle latency.
    task automatic single(input logic [1:0] tsz, input logic tsx, input logic [1:0] toff,
                          input logic twe, input logic [31:0] rd, input logic re,
                          input logic [31:0] exp_rd, input string tag);
        issue(tsz, tsx, toff, 2'b00, twe, 1'b1);
        sb.push_back({exp_rd, re});
        respond(rd, re, 1'b1);
        chk({tag, "_not_early"}, {31'd0, lsu_valid_o}, 32'd0);
        idle(1'b1);
        chk({tag, "_latency"}, {31'd0, lsu_valid_o}, 32'd1);
        idle(1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_t ld;
        logic [31:0] rd;
        int issued;
        bit  tv;

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, lsu_valid_o}, 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        chk("rst_err", {31'd0, lsu_err_o}, 32'd0);
        chk("rst_ready", {31'd0, trans_ready_o}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Aligned accesses of each size
        single(2'b10, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, "word");
        single(2'b00, 1'b1, 2'd2, 1'b0, 32'h0080_0000, 1'b0, 32'hFFFFFF80, "sbyte");
        single(2'b00, 1'b0, 2'd2, 1'b0, 32'h0080_0000, 1'b0, 32'h00000080, "ubyte");
        single(2'b01, 1'b1, 2'd2, 1'b0, 32'h8001_0000, 1'b0, 32'hFFFF8001, "shalf");
        single(2'b10, 1'b0, 2'd0, 1'b1, 32'h12345678, 1'b1, 32'h00000000, "store");

        // Split word load at offset 1, error on the second half
        issue(2'b10, 1'b0, 2'd1, 2'b01, 1'b0, 1'b1);
        issue(2'b10, 1'b0, 2'd1, 2'b10, 1'b0, 1'b1);
        respond(32'h332211AA, 1'b0, 1'b1);
        chk("split_credit_full", {31'd0, trans_ready_o}, 32'd0);
        sb.push_back({32'h44332211, 1'b1});
        respond(32'h55667744, 1'b1, 1'b1);
        chk("split_no_first_out", {31'd0, lsu_valid_o}, 32'd0);
        idle(1'b1);
        chk("split_latency", {31'd0, lsu_valid_o}, 32'd1);
        idle(1'b1);
        chk("split_single_result", {31'd0, lsu_valid_o}, 32'd0);

        // Stall: two loads buffered while WB is not ready
        issue(2'b10, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
        chk("stall_ready_one", {31'd0, trans_ready_o}, 32'd1);
        issue(2'b10, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
        idle(1'b0);
        chk("stall_credit_drop", {31'd0, trans_ready_o}, 32'd0);
        sb.push_back({32'h11111111, 1'b0});
        respond(32'h11111111, 1'b0, 1'b0);
        sb.push_back({32'h22222222, 1'b0});
        respond(32'h22222222, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("stall_full_ready", {31'd0, trans_ready_o}, 32'd0);
        idle(1'b1);
        idle(1'b1);
        chk("stall_back_to_back", {31'd0, lsu_valid_o}, 32'd1);
        chk("stall_credit_free", {31'd0, trans_ready_o}, 32'd1);
        idle(1'b1);
        chk("stall_drained", sb.size(), 32'd0);

        // Continuous traffic with WB always ready, crossing pointer wrap
        issued = 0;
        for (int c = 0; c < 80 && (issued < 12 || pend.size() != 0 || sb.size() != 0); c++) begin
            @(negedge clk);
            if (pend.size() != 0) begin
                ld = pend.pop_front();
                rd = $urandom;
                sb.push_back({exp_load(rd, ld), 1'b0});
                resp_valid_i = 1'b1;
                resp_rdata_i = rd;
            end else begin
                resp_valid_i = 1'b0;
                resp_rdata_i = 32'd0;
            end
            tv = (trans_ready_o === 1'b1) && (issued < 12);
            ld.size = 2'($urandom_range(0, 2));
            ld.sext = 1'($urandom_range(0, 1));
            ld.we   = ($urandom_range(0, 3) == 0);
            if (ld.size == 2'd0) ld.off = 2'($urandom_range(0, 3));
            else if (ld.size == 2'd1) ld.off = {1'($urandom_range(0, 1)), 1'b0};
            else ld.off = 2'd0;
            trans_valid_i  = tv;
            trans_size_i   = ld.size;
            trans_sext_i   = ld.sext;
            trans_offset_i = ld.off;
            trans_split_i  = 2'b00;
            trans_we_i     = ld.we;
            resp_err_i     = 1'b0;
            lsu_ready_i    = 1'b1;
            #1;
            observe();
            if (tv) begin
                pend.push_back(ld);
                issued++;
            end
        end
        idle(1'b1);
        chk("stream_issued", issued, 32'd12);
        chk("stream_drained", sb.size() + pend.size(), 32'd0);

        // Asynchronous reset with one result buffered and one load pending
        issue(2'b10, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
        sb.push_back({32'h5A5A5A5A, 1'b1});
        respond(32'h5A5A5A5A, 1'b1, 1'b0);
        issue(2'b10, 1'b0, 2'd0, 2'b00, 1'b0, 1'b0);
        chk("pre_rst_valid", {31'd0, lsu_valid_o}, 32'd1);
        @(negedge clk);
        set_in(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, lsu_valid_o}, 32'd0);
        chk("arst_rdata", lsu_rdata_o, 32'd0);
        chk("arst_err", {31'd0, lsu_err_o}, 32'd0);
        sb.delete();
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1);
        chk("post_rst_ready", {31'd0, trans_ready_o}, 32'd1);
        idle(1'b1);
        chk("post_rst_valid", {31'd0, lsu_valid_o}, 32'd0);
        single(2'b10, 1'b0, 2'd0, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, "post_rst_word");
        chk("final_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
